// File: rtl/my_video_filter_mul_pkg.sv
// Shared constants, tag type and round-robin helper for the shared multiplier arbiter.
// Pure declarations: no latency, no flow control.
package my_video_filter_mul_pkg;

  localparam int DIN_WIDTH  = 16;
  localparam int DOUT_WIDTH = 2 * DIN_WIDTH;
  localparam int MAX_REQ    = 8;

  // One-hot requester tag, sized for the largest supported requester count.
  typedef logic [MAX_REQ-1:0] tag_t;

  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
  } rr_pick_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

  // First set bit of vld at or after ptr, wrapping modulo n.
  function automatic rr_pick_t rr_next(input tag_t vld, input logic [2:0] ptr, input int n);
    rr_pick_t   p;
    int         pos;
    logic [2:0] pos3;
    p = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      pos  = (int'(ptr) + k) % n;
      pos3 = 3'(pos);
      if (k < n && !p.hit && vld[pos3]) begin
        p.hit = 1'b1;
        p.idx = pos3;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/my_video_filter_mul_arbiter_if.sv
// Requester/response bundle between the filter channels and the shared multiplier arbiter.
// Request side is valid/ready; response side is valid-only with no backpressure.
interface my_video_filter_mul_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DIN_WIDTH  = 16,
  parameter int DOUT_WIDTH = 32
);
  logic                         en;
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ*DIN_WIDTH-1:0] req_a;
  logic [NUM_REQ*DIN_WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]           rsp_valid;
  logic [DOUT_WIDTH-1:0]        rsp_data;
  logic [2:0]                   inflight;

  modport master (
    output en, req_valid, req_a, req_b,
    input  req_ready, rsp_valid, rsp_data, inflight
  );

  modport slave (
    input  en, req_valid, req_a, req_b,
    output req_ready, rsp_valid, rsp_data, inflight
  );
endinterface

// File: rtl/my_video_filter_mul_pipe.sv
// Registered unsigned multiplier, DEPTH stages, carrying a one-hot tag and valid alongside.
// Latency DEPTH cycles (combinational when DEPTH=0); accepts one operation every cycle, no stall.
module my_video_filter_mul_pipe
  import my_video_filter_mul_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DIN_WIDTH  = 16,
  parameter int DOUT_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_vld,
  input  logic [NUM_REQ-1:0]    in_tag,
  input  logic [DIN_WIDTH-1:0]  in_a,
  input  logic [DIN_WIDTH-1:0]  in_b,
  output logic                  out_vld,
  output logic [NUM_REQ-1:0]    out_tag,
  output logic [DOUT_WIDTH-1:0] out_dat
);

  logic [DOUT_WIDTH-1:0] prod;
  assign prod = DOUT_WIDTH'(in_a) * DOUT_WIDTH'(in_b);

  generate
    if (DEPTH == 0) begin : g_comb
      assign out_vld = in_vld;
      assign out_tag = in_tag;
      assign out_dat = prod;
    end else begin : g_reg
      logic [DEPTH-1:0]                 vld_q;
      logic [DEPTH-1:0][NUM_REQ-1:0]    tag_q;
      logic [DEPTH-1:0][DOUT_WIDTH-1:0] dat_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          vld_q <= '0;
          tag_q <= '0;
        end else begin
          vld_q[0] <= in_vld;
          tag_q[0] <= in_tag;
          for (int k = 1; k < DEPTH; k++) begin
            vld_q[k] <= vld_q[k-1];
            tag_q[k] <= tag_q[k-1];
          end
        end
      end

      // Product stages carry no reset so retiming can pull them into the DSP pipeline.
      always_ff @(posedge clk) begin
        dat_q[0] <= prod;
        for (int k = 1; k < DEPTH; k++) begin
          dat_q[k] <= dat_q[k-1];
        end
      end

      assign out_vld = vld_q[DEPTH-1];
      assign out_tag = tag_q[DEPTH-1];
      assign out_dat = dat_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/my_video_filter_mul_arbiter.sv
// Round-robin share of one pipelined multiplier; product returns MUL_LATENCY cycles after handshake.
// One grant per cycle when en=1; responses are valid-only, requesters must take them when shown.
module my_video_filter_mul_arbiter
  import my_video_filter_mul_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DIN_WIDTH   = 16,
  parameter int DOUT_WIDTH  = 32,
  parameter int MUL_LATENCY = 3
) (
  input  logic                          ap_clk,
  input  logic                          ap_rst,
  my_video_filter_mul_arbiter_if.slave  bus
);

  localparam int PTR_W = clog2(NUM_REQ);

  logic [PTR_W-1:0]      rr_ptr;
  logic [PTR_W-1:0]      rr_ptr_nxt;
  tag_t                  vld_ext;
  rr_pick_t              pick;
  logic [NUM_REQ-1:0]    grant;
  logic                  fire;
  logic [DIN_WIDTH-1:0]  sel_a;
  logic [DIN_WIDTH-1:0]  sel_b;

  logic                  pipe_vld;
  logic [NUM_REQ-1:0]    pipe_tag;
  logic [DOUT_WIDTH-1:0] pipe_dat;

  logic [NUM_REQ-1:0]    rsp_valid_q;
  logic [DOUT_WIDTH-1:0] rsp_data_q;
  logic [2:0]            inflight_q;

  always_comb begin
    vld_ext                = '0;
    vld_ext[NUM_REQ-1:0]   = bus.req_valid;
    pick                   = rr_next(vld_ext, 3'(rr_ptr), NUM_REQ);
    grant                  = '0;
    fire                   = 1'b0;
    rr_ptr_nxt             = rr_ptr;
    if (bus.en && !ap_rst && pick.hit) begin
      fire       = 1'b1;
      grant      = NUM_REQ'(1) << pick.idx;
      rr_ptr_nxt = (pick.idx == 3'(NUM_REQ-1)) ? '0 : PTR_W'(pick.idx + 3'd1);
    end
  end

  // Grant is one-hot, so an AND-OR mux picks the winner's operands.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_a = sel_a | bus.req_a[i*DIN_WIDTH +: DIN_WIDTH];
        sel_b = sel_b | bus.req_b[i*DIN_WIDTH +: DIN_WIDTH];
      end
    end
  end

  // The response register is the last latency stage, so the pipe holds one fewer.
  my_video_filter_mul_pipe #(
    .NUM_REQ    (NUM_REQ),
    .DIN_WIDTH  (DIN_WIDTH),
    .DOUT_WIDTH (DOUT_WIDTH),
    .DEPTH      (MUL_LATENCY - 1)
  ) u_pipe (
    .clk     (ap_clk),
    .rst     (ap_rst),
    .in_vld  (fire),
    .in_tag  (grant),
    .in_a    (sel_a),
    .in_b    (sel_b),
    .out_vld (pipe_vld),
    .out_tag (pipe_tag),
    .out_dat (pipe_dat)
  );

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      rr_ptr      <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      inflight_q  <= '0;
    end else begin
      rr_ptr      <= rr_ptr_nxt;
      rsp_valid_q <= pipe_vld ? pipe_tag : '0;
      if (pipe_vld) rsp_data_q <= pipe_dat;
      // An op stays counted through the cycle its response is presented.
      case ({fire, |rsp_valid_q})
        2'b10:   inflight_q <= inflight_q + 3'd1;
        2'b01:   inflight_q <= inflight_q - 3'd1;
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  assign bus.req_ready = grant;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.inflight  = inflight_q;

endmodule

// File: tb/tb_my_video_filter_mul_arbiter.sv
// Directed scenarios plus random traffic, each cycle compared against a queue-based reference model.
module tb_my_video_filter_mul_arbiter;
  import my_video_filter_mul_pkg::*;

  localparam int N = 4;
  localparam int L = 3;

  typedef struct {
    int          due;
    logic [N-1:0] tag;
    logic [31:0] prod;
  } item_t;

  logic  ap_clk = 1'b0;
  logic  ap_rst = 1'b1;
  always #5 ap_clk = ~ap_clk;

  my_video_filter_mul_arbiter_if #(.NUM_REQ(N), .DIN_WIDTH(16), .DOUT_WIDTH(32)) bus ();

  my_video_filter_mul_arbiter #(
    .NUM_REQ(N), .DIN_WIDTH(16), .DOUT_WIDTH(32), .MUL_LATENCY(L)
  ) dut (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .bus    (bus)
  );

  int          n_chk;
  int          n_fail;
  int          ptr;
  int          cyc;
  int          max_inf;
  logic [31:0] last_dat;
  item_t       q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [N*16-1:0] pk(input logic [15:0] x0, x1, x2, x3);
    return {x3, x2, x1, x0};
  endfunction

  // One clock cycle: drive, check against the model, clock, advance the model.
  task automatic cycle(input logic rst, input logic e, input logic [N-1:0] v,
                       input logic [N*16-1:0] a, input logic [N*16-1:0] b);
    logic [N-1:0] eg;
    logic [N-1:0] ev;
    logic [31:0]  p;
    item_t        it;
    int           gi;
    ap_rst        = rst;
    bus.en        = e;
    bus.req_valid = v;
    bus.req_a     = a;
    bus.req_b     = b;
    #1;
    eg = '0;
    gi = -1;
    if (!rst && e) begin
      for (int k = 0; k < N; k++) begin
        if (gi < 0 && v[(ptr + k) % N]) gi = (ptr + k) % N;
      end
    end
    if (gi >= 0) eg[gi] = 1'b1;
    chk("req_ready", 64'(bus.req_ready), 64'(eg));
    if (!rst) begin
      ev = '0;
      chk("inflight", 64'(bus.inflight), 64'(q.size()));
      if (int'(bus.inflight) > max_inf) max_inf = int'(bus.inflight);
      if (q.size() > 0 && q[0].due == cyc) begin
        it       = q.pop_front();
        ev       = it.tag;
        last_dat = it.prod;
      end
      chk("rsp_valid", 64'(bus.rsp_valid), 64'(ev));
      chk("rsp_data", 64'(bus.rsp_data), 64'(last_dat));
    end
    @(posedge ap_clk);
    if (rst) begin
      q.delete();
      ptr      = 0;
      last_dat = '0;
    end else if (gi >= 0) begin
      p = 32'(a[gi*16 +: 16]) * 32'(b[gi*16 +: 16]);
      q.push_back('{due: cyc + L, tag: eg, prod: p});
      ptr = (gi + 1) % N;
    end
    cyc++;
    @(negedge ap_clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, '0, '0, '0);
  endtask

  function automatic logic [N*16-1:0] rnd_ops();
    return {$urandom, $urandom};
  endfunction

  initial begin
    n_chk = 0; n_fail = 0; ptr = 0; cyc = 0; max_inf = 0; last_dat = '0;
    bus.en = 1'b0; bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0;

    repeat (2) cycle(1'b1, 1'b0, '0, '0, '0);

    // Single grant 3*5 on req0.
    cycle(1'b0, 1'b1, 4'b0001, pk(16'd3, 16'd0, 16'd0, 16'd0), pk(16'd5, 16'd0, 16'd0, 16'd0));
    idle(L + 1);
    chk("t1_data_hold", 64'(bus.rsp_data), 64'd15);

    // All four valid for 8 cycles from a fresh pointer.
    cycle(1'b1, 1'b0, '0, '0, '0);
    max_inf = 0;
    repeat (8) cycle(1'b0, 1'b1, 4'b1111, rnd_ops(), rnd_ops());
    idle(L + 1);
    chk("t2_inflight_sat", 64'(max_inf), 64'(L));

    // Extreme operands back-to-back.
    cycle(1'b0, 1'b1, 4'b0001, pk(16'hFFFF, 16'd0, 16'd0, 16'd0), pk(16'hFFFF, 16'd0, 16'd0, 16'd0));
    cycle(1'b0, 1'b1, 4'b0001, pk(16'h0000, 16'd0, 16'd0, 16'd0), pk(16'hFFFF, 16'd0, 16'd0, 16'd0));
    idle(1);
    chk("t3_max_product", 64'(bus.rsp_data), 64'h0000_0000_FFFE_0001);
    idle(1);
    chk("t3_zero_product", 64'(bus.rsp_data), 64'd0);
    idle(L);

    // Reset with two operations in flight.
    repeat (2) cycle(1'b0, 1'b1, 4'b0110, rnd_ops(), rnd_ops());
    cycle(1'b1, 1'b1, 4'b0110, rnd_ops(), rnd_ops());
    idle(L + 1);
    chk("t4_inflight_zero", 64'(bus.inflight), 64'd0);
    cycle(1'b0, 1'b1, 4'b1111, rnd_ops(), rnd_ops());
    idle(L + 1);

    // Enable dropped mid-burst, then re-asserted.
    repeat (2) cycle(1'b0, 1'b1, 4'b0110, rnd_ops(), rnd_ops());
    repeat (5) cycle(1'b0, 1'b0, 4'b0110, rnd_ops(), rnd_ops());
    repeat (3) cycle(1'b0, 1'b1, 4'b0110, rnd_ops(), rnd_ops());
    idle(L + 1);

    // Lone requester 3, then pointer wrap to req0.
    repeat (6) cycle(1'b0, 1'b1, 4'b1000, rnd_ops(), rnd_ops());
    cycle(1'b0, 1'b1, 4'b1111, rnd_ops(), rnd_ops());
    idle(L + 1);

    // Random traffic with occasional enable drops and resets.
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) != 0),
            4'($urandom), rnd_ops(), rnd_ops());
    end
    idle(L + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
